mod_exp_ctrl: RTL and testbench

//  Modular exponentiation controller: computes base^exponent mod modulus by left-to-right

---
 rtl/mod_exp_ctrl.sv | 133 +++++++++++++
 tb/tb_mod_exp_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_exp_ctrl.sv
// Modular exponentiation controller: left-to-right square-and-multiply around an external mul_mod.
// Build option MOD_EXP_SKIP_LEADING_ZEROS_EN: LOAD skips leading zero exponent bits (one bit per cycle).
module mod_exp_ctrl #(
   parameter int unsigned WIDTH     = 256,
   parameter int unsigned EXP_WIDTH = 256
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [WIDTH-1:0]     base,
   input  logic [EXP_WIDTH-1:0] exponent,
   input  logic [WIDTH-1:0]     modulus,
   output logic                 busy,
   output logic                 done,
   output logic [WIDTH-1:0]     result,
   output logic [WIDTH-1:0]     mm_y,
   output logic [WIDTH-1:0]     mm_z,
   output logic [WIDTH-1:0]     mm_n,
   output logic                 mm_ready,
   input  logic                 mm_valid,
   input  logic [WIDTH-1:0]     mm_M
);
   localparam int unsigned BW = $clog2(EXP_WIDTH) + 1;
   localparam int unsigned IW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;

   typedef enum logic [3:0] {
      IDLE, LOAD, SQ_ISSUE, SQ_GAP, SQ_WAIT, MUL_ISSUE, MUL_GAP, MUL_WAIT, FINISH
   } state_t;

   state_t                 state_q;
   logic                   busy_q, done_q, mm_ready_q;
   logic [WIDTH-1:0]       result_q, mm_y_q, mm_z_q, mm_n_q, acc_q, base_q;
   logic [EXP_WIDTH-1:0]   exp_q;
   logic [BW-1:0]          bit_idx_q;
   logic                   exp_bit, at_last;

   assign exp_bit = exp_q[bit_idx_q[IW-1:0]];
   assign at_last = (bit_idx_q == '0);

   // mm_n_q doubles as the captured modulus; it only changes on an accepted start.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         mm_ready_q <= 1'b0;
         result_q   <= '0;
         mm_y_q     <= '0;
         mm_z_q     <= '0;
         mm_n_q     <= '0;
         acc_q      <= '0;
         base_q     <= '0;
         exp_q      <= '0;
         bit_idx_q  <= '0;
      end else begin
         mm_ready_q <= 1'b0;
         done_q     <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  base_q    <= base;
                  exp_q     <= exponent;
                  mm_n_q    <= modulus;
                  acc_q     <= WIDTH'(1);
                  bit_idx_q <= BW'(EXP_WIDTH - 1);
                  busy_q    <= 1'b1;
                  state_q   <= LOAD;
               end
            end
            LOAD: begin
`ifdef MOD_EXP_SKIP_LEADING_ZEROS_EN
               if (exp_bit) begin
                  mm_y_q     <= acc_q;
                  mm_z_q     <= acc_q;
                  mm_ready_q <= 1'b1;
                  state_q    <= SQ_ISSUE;
               end else if (at_last) begin
                  result_q <= (mm_n_q == WIDTH'(1)) ? '0 : WIDTH'(1);
                  done_q   <= 1'b1;
                  state_q  <= FINISH;
               end else begin
                  bit_idx_q <= bit_idx_q - BW'(1);
               end
`else
               mm_y_q     <= acc_q;
               mm_z_q     <= acc_q;
               mm_ready_q <= 1'b1;
               state_q    <= SQ_ISSUE;
`endif
            end
            SQ_ISSUE:  state_q <= SQ_GAP;
            SQ_GAP:    state_q <= SQ_WAIT;
            MUL_ISSUE: state_q <= MUL_GAP;
            MUL_GAP:   state_q <= MUL_WAIT;
            SQ_WAIT, MUL_WAIT: begin
               if (mm_valid) begin
                  acc_q <= mm_M;
                  if (state_q == SQ_WAIT && exp_bit) begin
                     mm_y_q     <= mm_M;
                     mm_z_q     <= base_q;
                     mm_ready_q <= 1'b1;
                     state_q    <= MUL_ISSUE;
                  end else if (at_last) begin
                     result_q <= mm_M;
                     done_q   <= 1'b1;
                     state_q  <= FINISH;
                  end else begin
                     bit_idx_q  <= bit_idx_q - BW'(1);
                     mm_y_q     <= mm_M;
                     mm_z_q     <= mm_M;
                     mm_ready_q <= 1'b1;
                     state_q    <= SQ_ISSUE;
                  end
               end
            end
            FINISH: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign result   = result_q;
   assign mm_y     = mm_y_q;
   assign mm_z     = mm_z_q;
   assign mm_n     = mm_n_q;
   assign mm_ready = mm_ready_q;

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Self-checking bench for mod_exp_ctrl: behavioural mul_mod responder, right-to-left modexp reference,
// expected operand sequence and per-cycle protocol checks. Honours MOD_EXP_SKIP_LEADING_ZEROS_EN.
module tb_mod_exp_ctrl;
   localparam int unsigned W = 256;
   localparam int unsigned E = 256;
`ifdef MOD_EXP_SKIP_LEADING_ZEROS_EN
   localparam bit SKIP      = 1'b1;
   localparam int OPS_A     = 7;
   localparam int OPS_ZERO  = 0;
   localparam int NRAND     = 10;
`else
   localparam bit SKIP      = 1'b0;
   localparam int OPS_A     = 259;
   localparam int OPS_ZERO  = 256;
   localparam int NRAND     = 6;
`endif

   typedef struct packed {
      logic [W-1:0] y;
      logic [W-1:0] z;
   } op_t;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic [W-1:0]  base = '0;
   logic [E-1:0]  exponent = '0;
   logic [W-1:0]  modulus = '0;
   logic          busy, done, mm_ready;
   logic [W-1:0]  result, mm_y, mm_z, mm_n;
   logic          mm_valid;
   logic [W-1:0]  mm_M;

   int            checks = 0;
   int            failures = 0;
   op_t           op_q[$];
   op_t           cur_op;
   logic [W-1:0]  exp_result = '0;
   logic [W-1:0]  exp_mod = '0;
   int            launches = 0;
   int            lat_seen = 0;

   always #5 clk = ~clk;

   mod_exp_ctrl #(.WIDTH(W), .EXP_WIDTH(E)) dut (
      .clk(clk), .reset(reset), .start(start), .base(base), .exponent(exponent),
      .modulus(modulus), .busy(busy), .done(done), .result(result), .mm_y(mm_y),
      .mm_z(mm_z), .mm_n(mm_n), .mm_ready(mm_ready), .mm_valid(mm_valid), .mm_M(mm_M)
   );

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic logic [W-1:0] mulmod(input logic [W-1:0] y, input logic [W-1:0] z,
                                           input logic [W-1:0] n);
      logic [2*W-1:0] p;
      if (n == '0) return '0;
      p = {{W{1'b0}}, y} * {{W{1'b0}}, z};
      p = p % {{W{1'b0}}, n};
      return p[W-1:0];
   endfunction

   // Right-to-left reference, deliberately a different algorithm from the controller.
   function automatic logic [W-1:0] ref_modexp(input logic [W-1:0] b, input logic [E-1:0] e,
                                               input logic [W-1:0] m);
      logic [W-1:0] r, sq;
      r  = mulmod(W'(1), W'(1), m);
      sq = mulmod(b, W'(1), m);
      for (int i = 0; i < E; i++) begin
         if (e[i]) r = mulmod(r, sq, m);
         sq = mulmod(sq, sq, m);
      end
      return r;
   endfunction

   function automatic logic [W-1:0] rand_w();
      logic [W-1:0] r;
      for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   function automatic logic [E-1:0] rand_e();
      logic [E-1:0] r;
      for (int i = 0; i < E / 32; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   task automatic register_job(input logic [W-1:0] b, input logic [E-1:0] e, input logic [W-1:0] m);
      logic [W-1:0] acc;
      bit           started;
      op_q.delete();
      acc     = W'(1);
      started = !SKIP;
      for (int i = E - 1; i >= 0; i--) begin
         if (e[i]) started = 1'b1;
         if (started) begin
            op_q.push_back('{y: acc, z: acc});
            acc = mulmod(acc, acc, m);
            if (e[i]) begin
               op_q.push_back('{y: acc, z: b});
               acc = mulmod(acc, b, m);
            end
         end
      end
      exp_result = ref_modexp(b, e, m);
      exp_mod    = m;
      launches   = 0;
   endtask

   // Behavioural mul_mod: valid drops on launch, rises after a random latency, then stays high.
   logic         pend;
   int           lat;
   logic [W-1:0] prod;
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         mm_valid <= 1'b0;
         mm_M     <= '0;
         pend     <= 1'b0;
         lat      <= 0;
         prod     <= '0;
      end else if (mm_ready) begin
         int l;
         l = int'($urandom_range(0, 3));
         mm_valid <= 1'b0;
         pend     <= 1'b1;
         lat      <= l;
         lat_seen <= l;
         prod     <= mulmod(mm_y, mm_z, mm_n);
      end else if (pend) begin
         if (lat == 0) begin
            mm_valid <= 1'b1;
            mm_M     <= prod;
            pend     <= 1'b0;
         end else begin
            lat <= lat - 1;
         end
      end
   end

   // Per-cycle compare: operand sequence, launch spacing, operand stability, done/result/busy.
   logic         prev_ready = 1'b0, prev_done = 1'b0, hold = 1'b0;
   logic [W-1:0] hy, hz, hn;
   int           cyc = 0;
   always @(negedge clk) begin
      if (!reset) begin
         prev_ready = 1'b0;
         prev_done  = 1'b0;
         hold       = 1'b0;
         cyc        = 0;
      end else begin
         if (hold) cyc++;
         if (mm_ready) begin
            check("ready_single_cycle", W'(prev_ready), '0);
            if (hold) check("op_cycles", W'(cyc), W'(3 + lat_seen));
            launches++;
            if (op_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL extra_launch actual=launch required=none y=%0h z=%0h", mm_y, mm_z);
            end else begin
               cur_op = op_q.pop_front();
               check("op_y", mm_y, cur_op.y);
               check("op_z", mm_z, cur_op.z);
            end
            check("op_n", mm_n, exp_mod);
            hold = 1'b1;
            cyc  = 0;
            hy = mm_y; hz = mm_z; hn = mm_n;
         end else if (hold) begin
            check("stable_y", mm_y, hy);
            check("stable_z", mm_z, hz);
            check("stable_n", mm_n, hn);
         end
         if (done) begin
            check("done_single_cycle", W'(prev_done), '0);
            if (hold) check("last_op_cycles", W'(cyc), W'(3 + lat_seen));
            check("result", result, exp_result);
            check("ops_left", W'(op_q.size()), '0);
            hold = 1'b0;
         end
         if (prev_done && !done) check("busy_after_done", W'(busy), '0);
         prev_ready = mm_ready;
         prev_done  = done;
      end
   end

   task automatic launch(input logic [W-1:0] b, input logic [E-1:0] e, input logic [W-1:0] m);
      register_job(b, e, m);
      @(negedge clk);
      start = 1'b1; base = b; exponent = e; modulus = m;
      @(negedge clk);
      start = 1'b0;
      check("busy_after_start", W'(busy), W'(1));
   endtask

   task automatic wait_done(input string name);
      bit seen = 1'b0;
      for (int n = 0; n < 20000; n++) begin
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         checks++;
         failures++;
         $display("FAIL %s_timeout actual=no_done required=done", name);
      end
   endtask

   task automatic run_job(input string name, input logic [W-1:0] b, input logic [E-1:0] e,
                          input logic [W-1:0] m, input bit lit_en, input logic [W-1:0] lit,
                          input int lit_ops);
      launch(b, e, m);
      wait_done(name);
      if (lit_en) check({name, "_literal"}, result, lit);
      if (lit_ops >= 0) check({name, "_ops"}, W'(launches), W'(lit_ops));
      @(negedge clk);
   endtask

   initial begin
      #200000000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [W-1:0] rb, rm;
      logic [E-1:0] re;
      bit           seen;

      repeat (2) @(negedge clk);
      check("rst_busy", W'(busy), '0);
      check("rst_done", W'(done), '0);
      check("rst_ready", W'(mm_ready), '0);
      check("rst_result", result, '0);
      check("rst_y", mm_y, '0);
      check("rst_z", mm_z, '0);
      check("rst_n", mm_n, '0);
      reset = 1'b1;
      @(negedge clk);

      run_job("a4_13_497", W'(4), E'(13), W'(497), 1'b1, W'(445), OPS_A);
      run_job("a2_10_1000", W'(2), E'(10), W'(1000), 1'b1, W'(24), -1);
      run_job("a1234_1_1000", W'(1234), E'(1), W'(1000), 1'b1, W'(234), -1);
      run_job("exp0_mod7", W'(9), E'(0), W'(7), 1'b1, W'(1), OPS_ZERO);
      run_job("exp0_mod1", W'(9), E'(0), W'(1), 1'b1, W'(0), OPS_ZERO);
      run_job("exp5_mod1", W'(3), E'(5), W'(1), 1'b1, W'(0), -1);

      // start while busy with different operands must be ignored
      launch(W'(4), E'(13), W'(497));
      repeat (5) @(negedge clk);
      start = 1'b1; base = W'(2); exponent = E'(10); modulus = W'(1000);
      @(negedge clk);
      start = 1'b0;
      check("busy_ignored_start", W'(busy), W'(1));
      wait_done("ignored_start");
      check("ignored_start_literal", result, W'(445));
      @(negedge clk);

      // reset while waiting on the first base multiply
      launch(W'(4), E'(13), W'(497));
      seen = 1'b0;
      for (int n = 0; n < 20000; n++) begin
         @(negedge clk);
         if (mm_ready && mm_z == W'(4) && mm_y == W'(1)) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         checks++;
         failures++;
         $display("FAIL mul_launch_timeout actual=no_launch required=launch");
      end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1;
      op_q.delete();
      check("midrst_busy", W'(busy), '0);
      check("midrst_ready", W'(mm_ready), '0);
      check("midrst_result", result, '0);
      check("midrst_done", W'(done), '0);
      repeat (3) @(negedge clk);
      check("midrst_done_held", W'(done), '0);
      reset = 1'b1;
      @(negedge clk);
      run_job("after_reset", W'(4), E'(13), W'(497), 1'b1, W'(445), OPS_A);

      for (int k = 0; k < NRAND; k++) begin
         rb = rand_w();
         rm = rand_w() >> $urandom_range(0, W - 4);
         if (rm == '0) rm = W'(3);
         re = rand_e() >> $urandom_range(0, E - 1);
         run_job("random", rb, re, rm, 1'b0, '0, -1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
